// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: opcode classes, sequencer states and pc_src codes
package cpu_seq_pkg;
    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_JUMPR  = 4'b0001;
    localparam logic [3:0] OP_BRANCH = 4'b0110;
    localparam logic [3:0] OP_RETI   = 4'b0111;
    localparam logic [3:0] OP_JUMP   = 4'b1001;
    localparam logic [3:0] OP_WRITE  = 4'b1101;
    localparam logic [3:0] OP_READ   = 4'b1110;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_TGT = 2'd1;
    localparam logic [1:0] PC_VEC = 2'd2;
    localparam logic [1:0] PC_RET = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_MEM, S_MWAIT, S_WB, S_INT, S_HALT
    } state_t;

    function automatic logic op_is_alu(input logic [3:0] op);
        return !(op inside {OP_NOP, OP_JUMPR, OP_BRANCH, OP_RETI, OP_JUMP, OP_WRITE, OP_READ, OP_HALT});
    endfunction
endpackage

// File: rtl/bus_req_ctrl.sv
// bus_req_ctrl: bus request pulse, address/write qualifiers, outstanding tracking, sticky error
module bus_req_ctrl (
    input  logic clk,
    input  logic reset,
    input  logic fetch_req,
    input  logic mem_req,
    input  logic mem_we,
    input  logic bus_done,
    output logic bus_start,
    output logic bus_we,
    output logic addr_sel,
    output logic busy,
    output logic bus_err
);
    logic pend, pend_we, sel_q, we_q;

    // Data requests launch one cycle after MEM so the ALU address is stable
    assign bus_start = fetch_req | pend;
    assign addr_sel  = pend | (busy & sel_q);
    assign bus_we    = pend_we | (busy & we_q);

    // Track the pending launch, the outstanding transaction and stray completions
    always_ff @(posedge clk) begin
        if (reset) begin
            pend    <= 1'b0;
            pend_we <= 1'b0;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            busy    <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            pend    <= mem_req;
            pend_we <= mem_req & mem_we;
            if (bus_start) begin
                busy  <= 1'b1;
                sel_q <= pend;
                we_q  <= pend_we;
            end else if (bus_done) begin
                busy <= 1'b0;
            end
            if (bus_done && !busy) bus_err <= 1'b1;
        end
    end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/memory/writeback control with one interrupt line
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          instrOP,
    input  logic                branch_taken,
    input  logic                bus_done,
    input  logic                int_req,
    output logic                bus_start,
    output logic                bus_we,
    output logic                addr_sel,
    output logic                fetch,
    output logic                getRegs,
    output logic                alu_en,
    output logic                reg_we,
    output logic                pc_we,
    output logic [1:0]          pc_src,
    output logic                pc_save,
    output logic                int_ack,
    output logic                halted,
    output logic                bus_err,
    output logic [RETIRE_W-1:0] retired
);
    state_t state, state_nxt;
    logic in_isr, taken_q, busy, done_ok, is_mem, to_tgt;

    assign done_ok = bus_done & busy;
    assign is_mem  = (instrOP == OP_READ) || (instrOP == OP_WRITE);
    assign to_tgt  = (instrOP == OP_JUMP) || (instrOP == OP_JUMPR) || (instrOP == OP_BRANCH && taken_q);

    bus_req_ctrl u_bus (
        .clk       (clk),
        .reset     (reset),
        .fetch_req (state == S_FETCH && !reset),
        .mem_req   (state == S_MEM),
        .mem_we    (instrOP == OP_WRITE),
        .bus_done  (bus_done),
        .bus_start (bus_start),
        .bus_we    (bus_we),
        .addr_sel  (addr_sel),
        .busy      (busy),
        .bus_err   (bus_err)
    );

    // State register plus ISR flag, latched branch result and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            in_isr  <= 1'b0;
            taken_q <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INT) in_isr <= 1'b1;
            else if (state == S_WB && instrOP == OP_RETI) in_isr <= 1'b0;
            if (state == S_EXEC) taken_q <= branch_taken;
            if (state == S_WB) retired <= retired + RETIRE_W'(1);
        end
    end

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  state_nxt = S_FWAIT;
            S_FWAIT:  state_nxt = done_ok ? S_DECODE : S_FWAIT;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = is_mem ? S_MEM : (instrOP == OP_HALT) ? S_HALT : S_WB;
            S_MEM:    state_nxt = S_MWAIT;
            S_MWAIT:  state_nxt = done_ok ? S_WB : S_MWAIT;
            S_WB:     state_nxt = (int_req && !in_isr) ? S_INT : S_FETCH;
            S_INT:    state_nxt = S_FETCH;
            default:  state_nxt = state;
        endcase
    end

    // Datapath strobes decoded from the current state
    always_comb begin
        fetch   = (state == S_FWAIT) && done_ok;
        getRegs = state == S_DECODE;
        alu_en  = state == S_EXEC;
        reg_we  = ((state == S_MWAIT) && done_ok && instrOP == OP_READ) || ((state == S_WB) && op_is_alu(instrOP));
        pc_we   = (state == S_WB) || (state == S_INT);
        pc_src  = (state == S_INT) ? PC_VEC :
                  (state != S_WB) ? PC_INC :
                  to_tgt ? PC_TGT :
                  (instrOP == OP_RETI) ? PC_RET : PC_INC;
        pc_save = state == S_INT;
        int_ack = state == S_INT;
        halted  = state == S_HALT;
    end
endmodule
